// File: rtl/program_loader.sv
// Boot loader: framed byte stream -> program memory words.
// Keeps the core in reset until a checksummed frame is loaded.
module program_loader #(
  parameter int MEMORY_DEPTH   = 64,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start_i,
  input  logic        byte_valid_i,
  input  logic [7:0]  byte_i,
  output logic        byte_ready_o,
  output logic        prog_we_o,
  output logic [31:0] prog_addr_o,
  output logic [31:0] prog_data_o,
  output logic        cpu_reset_n_o,
  output logic        done_o,
  output logic        error_o,
  output logic [15:0] words_loaded_o
);

  localparam int IW = (MEMORY_DEPTH > 1) ? $clog2(MEMORY_DEPTH) : 1;
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [2:0] {
    IDLE, LEN_HI, LEN_LO, DATA, CHECK, DONE, ERROR
  } state_t;

  state_t          state;
  logic [15:0]     len;
  logic [23:0]     word;
  logic [1:0]      byte_cnt;
  logic [IW-1:0]   word_index;
  logic [7:0]      csum;
  logic [TW-1:0]   timer;

  logic            accept;
  logic            expired;
  logic            timeout;
  logic            last_word;
  logic [15:0]     len_full;
  logic [31:0]     full_word;

  assign accept    = byte_valid_i & byte_ready_o;
  assign expired   = timer == TW'(TIMEOUT_CYCLES - 1);
  assign timeout   = byte_ready_o & ~accept & expired;
  assign last_word = words_loaded_o == len - 16'd1;
  assign len_full  = {len[15:8], byte_i};
  assign full_word = {word, byte_i};

  // Frame FSM with registered outputs and idle-gap watchdog
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state          <= IDLE;
      len            <= '0;
      word           <= '0;
      byte_cnt       <= '0;
      word_index     <= '0;
      csum           <= '0;
      timer          <= '0;
      byte_ready_o   <= 1'b0;
      prog_we_o      <= 1'b0;
      prog_addr_o    <= '0;
      prog_data_o    <= '0;
      cpu_reset_n_o  <= 1'b0;
      done_o         <= 1'b0;
      error_o        <= 1'b0;
      words_loaded_o <= '0;
    end else begin
      prog_we_o <= 1'b0;
      if (byte_ready_o && !accept && !expired)
        timer <= timer + 1'b1;
      else
        timer <= '0;
      if (timeout) begin
        state        <= ERROR;
        byte_ready_o <= 1'b0;
        error_o      <= 1'b1;
      end else begin
        unique case (state)
          IDLE, DONE, ERROR: begin
            if (start_i) begin
              state          <= LEN_HI;
              byte_ready_o   <= 1'b1;
              cpu_reset_n_o  <= 1'b0;
              done_o         <= 1'b0;
              error_o        <= 1'b0;
              words_loaded_o <= '0;
              csum           <= '0;
              byte_cnt       <= '0;
              word_index     <= '0;
              word           <= '0;
            end
          end
          LEN_HI: begin
            if (accept) begin
              len[15:8] <= byte_i;
              state     <= LEN_LO;
            end
          end
          LEN_LO: begin
            if (accept) begin
              len <= len_full;
              if (len_full > 16'(MEMORY_DEPTH)) begin
                state        <= ERROR;
                byte_ready_o <= 1'b0;
                error_o      <= 1'b1;
              end else if (len_full == 16'd0) begin
                state <= CHECK;
              end else begin
                state <= DATA;
              end
            end
          end
          DATA: begin
            if (accept) begin
              word     <= full_word[23:0];
              csum     <= csum ^ byte_i;
              byte_cnt <= byte_cnt + 2'd1;
              if (byte_cnt == 2'd3) begin
                prog_we_o      <= 1'b1;
                prog_addr_o    <= {{(30-IW){1'b0}}, word_index, 2'b00};
                prog_data_o    <= full_word;
                words_loaded_o <= words_loaded_o + 16'd1;
                if (word_index != IW'(MEMORY_DEPTH - 1))
                  word_index <= word_index + 1'b1;
                if (last_word)
                  state <= CHECK;
              end
            end
          end
          CHECK: begin
            if (accept) begin
              byte_ready_o <= 1'b0;
              if (byte_i == csum) begin
                state         <= DONE;
                done_o        <= 1'b1;
                cpu_reset_n_o <= 1'b1;
              end else begin
                state   <= ERROR;
                error_o <= 1'b1;
              end
            end
          end
          default: begin
            state        <= IDLE;
            byte_ready_o <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_program_loader.sv
// Bench for program_loader: frame-level model predicts writes
// and final status; a monitor checks every write strobe.
module tb_program_loader;

  localparam int DEPTH = 64;
  localparam int TMO   = 1024;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start_i = 1'b0;
  logic        byte_valid_i = 1'b0;
  logic [7:0]  byte_i = '0;
  logic        byte_ready_o;
  logic        prog_we_o;
  logic [31:0] prog_addr_o;
  logic [31:0] prog_data_o;
  logic        cpu_reset_n_o;
  logic        done_o;
  logic        error_o;
  logic [15:0] words_loaded_o;

  program_loader #(
    .MEMORY_DEPTH(DEPTH),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk),
    .reset(reset),
    .start_i(start_i),
    .byte_valid_i(byte_valid_i),
    .byte_i(byte_i),
    .byte_ready_o(byte_ready_o),
    .prog_we_o(prog_we_o),
    .prog_addr_o(prog_addr_o),
    .prog_data_o(prog_data_o),
    .cpu_reset_n_o(cpu_reset_n_o),
    .done_o(done_o),
    .error_o(error_o),
    .words_loaded_o(words_loaded_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  wr_t         exp_q[$];
  logic [31:0] frame_words[$];
  logic [31:0] last_addr = '0;
  logic [31:0] last_data = '0;
  int          checks = 0;
  int          errors = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h want=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // Write-strobe monitor and core-release invariant, every cycle
  always @(negedge clk) begin
    if (prog_we_o === 1'b1) begin
      last_addr = prog_addr_o;
      last_data = prog_data_o;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write addr=%h data=%h",
                 prog_addr_o, prog_data_o);
      end else begin
        wr_t w;
        w = exp_q.pop_front();
        chk("wr_addr", prog_addr_o, w.addr);
        chk("wr_data", prog_data_o, w.data);
      end
    end
    chk("cpu_rst_vs_done", {31'd0, cpu_reset_n_o}, {31'd0, done_o});
  end

  function automatic logic [7:0] model_csum(input int n);
    logic [7:0] c;
    c = '0;
    for (int i = 0; i < n; i++)
      c ^= frame_words[i][31:24] ^ frame_words[i][23:16]
         ^ frame_words[i][15:8]  ^ frame_words[i][7:0];
    return c;
  endfunction

  task automatic pulse_start();
    start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int cnt;
    cnt = 0;
    byte_valid_i = 1'b1;
    byte_i = b;
    while (byte_ready_o !== 1'b1 && cnt < 20) begin
      @(negedge clk);
      cnt++;
    end
    if (cnt >= 20) begin
      checks++;
      errors++;
      $display("FAIL ready_wait got=0 want=1 byte=%h", b);
    end
    @(negedge clk);
  endtask

  task automatic run_frame(input logic [15:0] n, input logic [7:0] ck,
                           input int stall_after, input int stall_cycles);
    int  nw;
    int  k;
    bit  to;
    bit  stop;
    bit  exp_done;
    int  exp_words;
    to = (stall_after >= 0) && (stall_cycles >= TMO);
    if (n > 16'(DEPTH)) nw = 0;
    else if (to) nw = stall_after / 4;
    else nw = int'(n);
    for (int i = 0; i < nw; i++)
      exp_q.push_back('{addr: 32'(i * 4), data: frame_words[i]});
    exp_done = 1'b0;
    if (!to && n <= 16'(DEPTH))
      exp_done = (ck == model_csum(int'(n)));
    exp_words = nw;

    pulse_start();
    send_byte(n[15:8]);
    send_byte(n[7:0]);
    if (n <= 16'(DEPTH)) begin
      k = 0;
      stop = 1'b0;
      for (int i = 0; i < int'(n); i++) begin
        for (int b = 0; b < 4; b++) begin
          if (!stop && k == stall_after) begin
            byte_valid_i = 1'b0;
            for (int c = 1; c <= stall_cycles; c++) begin
              @(negedge clk);
              if (c == TMO - 1)
                chk("pre_timeout_err", {31'd0, error_o}, 32'd0);
              if (to && c == TMO)
                chk("timeout_err", {31'd0, error_o}, 32'd1);
            end
            if (to) stop = 1'b1;
          end
          if (!stop)
            send_byte(frame_words[i][31-8*b -: 8]);
          k++;
        end
      end
      if (!stop) send_byte(ck);
    end
    byte_valid_i = 1'b0;
    @(negedge clk);
    chk("done", {31'd0, done_o}, {31'd0, exp_done});
    chk("error", {31'd0, error_o}, {31'd0, !exp_done});
    chk("cpu_reset_n", {31'd0, cpu_reset_n_o}, {31'd0, exp_done});
    chk("words_loaded", {16'd0, words_loaded_o}, 32'(exp_words));
    chk("ready_after", {31'd0, byte_ready_o}, 32'd0);
    chk("writes_left", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1);
  end

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_ready", {31'd0, byte_ready_o}, 32'd0);
    chk("rst_cpu", {31'd0, cpu_reset_n_o}, 32'd0);
    chk("rst_done", {31'd0, done_o}, 32'd0);
    chk("rst_err", {31'd0, error_o}, 32'd0);
    chk("rst_words", {16'd0, words_loaded_o}, 32'd0);
    reset = 1'b1;
    @(negedge clk);
    start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    chk("ready_len_hi", {31'd0, byte_ready_o}, 32'd1);
    byte_valid_i = 1'b0;
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    // Two-word frame; XOR of the eight instruction bytes is 0x55
    frame_words = {32'h20080005, 32'h01095020};
    chk("model_csum_pin", {24'd0, model_csum(2)}, 32'h55);
    run_frame(16'd2, 8'h55, -1, 0);
    chk("lit_last_addr", last_addr, 32'h4);
    chk("lit_last_data", last_data, 32'h01095020);
    chk("lit_words", {16'd0, words_loaded_o}, 32'd2);

    run_frame(16'd2, 8'h1D, -1, 0);
    chk("lit_bad_err", {31'd0, error_o}, 32'd1);
    run_frame(16'd2, 8'h1C, -1, 0);

    frame_words = {};
    run_frame(16'h0041, 8'h00, -1, 0);
    run_frame(16'd0, 8'h00, -1, 0);
    chk("lit_zero_done", {31'd0, done_o}, 32'd1);
    run_frame(16'd0, 8'h01, -1, 0);

    frame_words = {32'hDEADBEEF};
    chk("model_csum_pin2", {24'd0, model_csum(1)}, 32'h22);
    run_frame(16'd1, 8'h22, 3, TMO);
    run_frame(16'd1, 8'h22, 3, TMO - 1);

    frame_words = {};
    for (int i = 0; i < DEPTH; i++)
      frame_words.push_back(32'(i) * 32'h01030507 ^ 32'hA5C3_0F96);
    run_frame(16'(DEPTH), model_csum(DEPTH), -1, 0);
    chk("lit_max_addr", last_addr, 32'hFC);

    // Reset in the middle of DATA after six bytes
    frame_words = {32'h11223344, 32'h55667788};
    exp_q.push_back('{addr: 32'h0, data: 32'h11223344});
    pulse_start();
    send_byte(8'h00);
    send_byte(8'h02);
    send_byte(8'h11);
    send_byte(8'h22);
    send_byte(8'h33);
    send_byte(8'h44);
    byte_valid_i = 1'b0;
    @(negedge clk);
    chk("pre_rst_writes", 32'(exp_q.size()), 32'd0);
    #2 reset = 1'b0;
    #1;
    chk("mid_rst_ready", {31'd0, byte_ready_o}, 32'd0);
    chk("mid_rst_we", {31'd0, prog_we_o}, 32'd0);
    chk("mid_rst_addr", prog_addr_o, 32'd0);
    chk("mid_rst_data", prog_data_o, 32'd0);
    chk("mid_rst_cpu", {31'd0, cpu_reset_n_o}, 32'd0);
    chk("mid_rst_done", {31'd0, done_o}, 32'd0);
    chk("mid_rst_err", {31'd0, error_o}, 32'd0);
    chk("mid_rst_words", {16'd0, words_loaded_o}, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    frame_words = {32'h0BADF00D};
    run_frame(16'd1, model_csum(1), -1, 0);
    chk("lit_post_rst_addr", last_addr, 32'h0);
    chk("lit_post_rst_data", last_data, 32'h0BADF00D);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
